// File: rtl/mcu_sequencer.sv
// ---------------------------------------------------------------------------
// mcu_sequencer
//
// Generates the 3-bit machine state decoded by the microcontroller control
// unit. It owns program loading (handshake, PMem write address, word count),
// the FETCH -> DECODE -> EXECUTE rotation, entry into and exit from STOP
// (halt / resume / reload), and a saturating retired-instruction counter.
//
// State encodings:
//     LOAD=3'b000  FETCH=3'b001  DECODE=3'b010  EXECUTE=3'b011  STOP=3'b100
//
// Ports:
//     clk             in   system clock, all state on rising edge
//     rst_n           in   asynchronous active-low reset
//     load_valid      in   program word on load_data is valid
//     load_data       in   program word [INSTR_W]
//     load_last       in   final word of program (only with load_valid)
//     load_ready      out  a load beat is accepted this cycle (state == LOAD)
//     pmem_load_we    out  accepted beat, PMem write strobe qualifier
//     pmem_load_addr  out  PMem write address for the current beat [ADDR_W]
//     pmem_load_data  out  PMem write data, pass-through of load_data
//     halt_req        in   level, stop at the next instruction boundary
//     resume          in   pulse, STOP -> FETCH
//     reload          in   pulse, STOP -> LOAD (wins over resume)
//     step_en         in   only with MCU_SEQ_STEP_EN: stop after every EXECUTE
//     state           out  machine state [3]
//     load_done       out  sticky, program load completed
//     load_full       out  sticky, load ended by address exhaustion
//     load_count      out  words accepted in the last/current load [ADDR_W+1]
//     retired         out  completed EXECUTE cycles, saturating [CNT_W]
//
// Build option:
//     MCU_SEQ_STEP_EN  adds the step_en input for single-step operation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mcu_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 12,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               pmem_load_we,
    output logic [ADDR_W-1:0]  pmem_load_addr,
    output logic [INSTR_W-1:0] pmem_load_data,
    input  logic               halt_req,
    input  logic               resume,
    input  logic               reload,
`ifdef MCU_SEQ_STEP_EN
    input  logic               step_en,
`endif
    output logic [2:0]         state,
    output logic               load_done,
    output logic               load_full,
    output logic [ADDR_W:0]    load_count,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_LOAD    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_EXECUTE = 3'b011,
        S_STOP    = 3'b100
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               done_q, done_d;
    logic               full_q, full_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic               accept;
    logic               at_last_addr;
    logic               stop_after_exec;

    assign accept       = load_valid && (state_q == S_LOAD);
    assign at_last_addr = (addr_q == ADDR_LAST);

`ifdef MCU_SEQ_STEP_EN
    assign stop_after_exec = halt_req || step_en;
`else
    assign stop_after_exec = halt_req;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        done_d    = done_q;
        full_d    = full_q;
        retired_d = retired_q;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    // count_q is one bit wider than the address, so a full
                    // 2**ADDR_W-word load fits without overflow.
                    count_d = count_q + 1'b1;
                    // At the top address the pointer is held rather than
                    // wrapped; it is cleared when LOAD is re-entered.
                    if (!at_last_addr) begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (load_last || at_last_addr) begin
                        state_d = S_FETCH;
                        done_d  = 1'b1;
                        full_d  = !load_last;
                    end
                end
            end

            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                state_d = S_EXECUTE;
            end

            S_EXECUTE: begin
                if (retired_q != CNT_MAX) begin
                    retired_d = retired_q + 1'b1;
                end
                // Halt is only looked at here, so an instruction already in
                // flight always completes.
                state_d = stop_after_exec ? S_STOP : S_FETCH;
            end

            S_STOP: begin
                if (reload) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    full_d  = 1'b0;
                end else if (resume) begin
                    state_d = S_FETCH;
                end
            end

            // Unreachable encodings park the machine safely in STOP.
            default: begin
                state_d = S_STOP;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LOAD;
            addr_q    <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            full_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            done_q    <= done_d;
            full_q    <= full_d;
            retired_q <= retired_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign state          = state_q;
    assign load_ready     = (state_q == S_LOAD);
    assign pmem_load_we   = accept;
    assign pmem_load_addr = addr_q;
    assign pmem_load_data = load_data;
    assign load_done      = done_q;
    assign load_full      = full_q;
    assign load_count     = count_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
`timescale 1ns/1ps

module tb_mcu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;

    // Main instance (default parameters)
    logic        load_valid, load_last;
    logic [11:0] load_data;
    logic        load_ready, pmem_load_we;
    logic [7:0]  pmem_load_addr;
    logic [11:0] pmem_load_data;
    logic        halt_req, resume, reload;
    logic [2:0]  state;
    logic        load_done, load_full;
    logic [8:0]  load_count;
    logic [15:0] retired;
`ifdef MCU_SEQ_STEP_EN
    logic        step_en;
`endif

    // Small instance (ADDR_W=2) for address exhaustion
    logic        s_load_valid, s_load_last;
    logic [11:0] s_load_data;
    logic        s_load_ready, s_pmem_load_we;
    logic [1:0]  s_pmem_load_addr;
    logic [11:0] s_pmem_load_data;
    logic [2:0]  s_state;
    logic        s_load_done, s_load_full;
    logic [2:0]  s_load_count;
    logic [15:0] s_retired;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [11:0] data;
    } beat_t;
    beat_t sb_q[$];

    always #5 clk = ~clk;

    mcu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .pmem_load_we(pmem_load_we),
        .pmem_load_addr(pmem_load_addr), .pmem_load_data(pmem_load_data),
        .halt_req(halt_req), .resume(resume), .reload(reload),
`ifdef MCU_SEQ_STEP_EN
        .step_en(step_en),
`endif
        .state(state), .load_done(load_done), .load_full(load_full),
        .load_count(load_count), .retired(retired)
    );

    mcu_sequencer #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .load_valid(s_load_valid), .load_data(s_load_data), .load_last(s_load_last),
        .load_ready(s_load_ready), .pmem_load_we(s_pmem_load_we),
        .pmem_load_addr(s_pmem_load_addr), .pmem_load_data(s_pmem_load_data),
        .halt_req(halt_req), .resume(resume), .reload(reload),
`ifdef MCU_SEQ_STEP_EN
        .step_en(1'b0),
`endif
        .state(s_state), .load_done(s_load_done), .load_full(s_load_full),
        .load_count(s_load_count), .retired(s_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    // Drive one load cycle on the selected instance (called at a negedge).
    // An expected accept is pushed to the scoreboard; an observed write
    // strobe pops it and compares address and data.
    task automatic beat(input bit sel, input bit v, input logic [11:0] d,
                        input bit last, input bit exp_acc, input int exp_addr);
        beat_t e, got;
        logic we;
        if (sel) begin
            s_load_valid = v; s_load_data = d; s_load_last = last;
        end else begin
            load_valid = v; load_data = d; load_last = last;
        end
        if (exp_acc) begin
            e.addr = 8'(exp_addr);
            e.data = d;
            sb_q.push_back(e);
        end
        #1;
        we       = sel ? s_pmem_load_we : pmem_load_we;
        got.addr = sel ? 8'(s_pmem_load_addr) : pmem_load_addr;
        got.data = sel ? s_pmem_load_data : pmem_load_data;
        chk("load_we", 32'(we), 32'(exp_acc));
        if (we) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_write", 32'(1), 32'(0));
            end else begin
                e = sb_q.pop_front();
                $display("beat sel=%0d addr=%0h data=%0h", sel, got.addr, got.data);
                chk("load_addr", 32'(got.addr), 32'(e.addr));
                chk("load_data", 32'(got.data), 32'(e.data));
            end
        end
        adv();
        if (sel) s_load_valid = 1'b0; else load_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        load_valid = 0; load_data = '0; load_last = 0;
        s_load_valid = 0; s_load_data = '0; s_load_last = 0;
        halt_req = 0; resume = 0; reload = 0;
`ifdef MCU_SEQ_STEP_EN
        step_en = 0;
`endif
        adv();
        chk("rst_state",   32'(state), 32'(0));
        chk("rst_addr",    32'(pmem_load_addr), 32'(0));
        chk("rst_count",   32'(load_count), 32'(0));
        chk("rst_done",    32'(load_done), 32'(0));
        chk("rst_full",    32'(load_full), 32'(0));
        chk("rst_retired", 32'(retired), 32'(0));
        chk("rst_ready",   32'(load_ready), 32'(1));
        rst_n = 1'b1;

        // Three back-to-back beats, last on the third
        beat(0, 1, 12'h101, 0, 1, 0);
        beat(0, 1, 12'h202, 0, 1, 1);
        beat(0, 1, 12'h3FF, 1, 1, 2);
        chk("load1_state", 32'(state), 32'(1));
        chk("load1_done",  32'(load_done), 32'(1));
        chk("load1_full",  32'(load_full), 32'(0));
        chk("load1_count", 32'(load_count), 32'(3));
        load_valid = 1; #1;
        chk("fetch_ready", 32'(load_ready), 32'(0));
        chk("fetch_we",    32'(pmem_load_we), 32'(0));
        load_valid = 0;

        // Five full instructions
        for (int i = 0; i < 5; i++) begin
            chk("run_fetch", 32'(state), 32'(1)); adv();
            chk("run_decode", 32'(state), 32'(2)); adv();
            chk("run_exec", 32'(state), 32'(3)); adv();
        end
        chk("run_retired5", 32'(retired), 32'(5));
        // Sixth, halt raised during DECODE
        chk("run6_fetch", 32'(state), 32'(1)); adv();
        chk("run6_decode", 32'(state), 32'(2));
        halt_req = 1; adv();
        chk("run6_exec", 32'(state), 32'(3)); adv();
        chk("halt_stop", 32'(state), 32'(4));
        chk("halt_retired", 32'(retired), 32'(6));
        halt_req = 0; adv();
        chk("stop_hold", 32'(state), 32'(4));

        // Resume with halt still high: exactly one instruction
        halt_req = 1; resume = 1; adv(); resume = 0;
        chk("res_fetch", 32'(state), 32'(1)); adv();
        chk("res_decode", 32'(state), 32'(2)); adv();
        chk("res_exec", 32'(state), 32'(3)); adv();
        chk("res_stop", 32'(state), 32'(4));
        chk("res_retired", 32'(retired), 32'(7));
        halt_req = 0;

        // Reload and resume together: reload wins
        reload = 1; resume = 1; adv(); reload = 0; resume = 0;
        chk("rl_state",   32'(state), 32'(0));
        chk("rl_addr",    32'(pmem_load_addr), 32'(0));
        chk("rl_count",   32'(load_count), 32'(0));
        chk("rl_done",    32'(load_done), 32'(0));
        chk("rl_full",    32'(load_full), 32'(0));
        chk("rl_retired", 32'(retired), 32'(7));

        // Gapped load; last without valid ignored; resume in LOAD ignored
        beat(0, 1, 12'h0A1, 0, 1, 0);
        beat(0, 0, 12'h0A2, 1, 0, 0);
        chk("gap1_state", 32'(state), 32'(0));
        resume = 1;
        beat(0, 0, 12'h000, 0, 0, 0);
        resume = 0;
        chk("gap2_state", 32'(state), 32'(0));
        beat(0, 1, 12'h0A3, 1, 1, 1);
        chk("gap_state", 32'(state), 32'(1));
        chk("gap_count", 32'(load_count), 32'(2));
        chk("gap_done",  32'(load_done), 32'(1));

        halt_req = 1; adv(); adv(); adv();
        chk("gap_stop", 32'(state), 32'(4));
        chk("gap_retired", 32'(retired), 32'(8));
        halt_req = 0;
        reload = 1; adv(); reload = 0;
        chk("rl2_state", 32'(state), 32'(0));

        // Partial load to address 5, then asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) beat(0, 1, 12'(12'h100 + i), 0, 1, i);
        chk("mid_addr", 32'(pmem_load_addr), 32'(5));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state",   32'(state), 32'(0));
        chk("arst_addr",    32'(pmem_load_addr), 32'(0));
        chk("arst_count",   32'(load_count), 32'(0));
        chk("arst_retired", 32'(retired), 32'(0));
        adv();
        rst_n = 1'b1;
        beat(0, 1, 12'h0AA, 1, 1, 0);
        chk("post_rst_state", 32'(state), 32'(1));
        chk("post_rst_count", 32'(load_count), 32'(1));

`ifdef MCU_SEQ_STEP_EN
        step_en = 1;
        chk("st_fetch", 32'(state), 32'(1)); adv();
        chk("st_decode", 32'(state), 32'(2)); adv();
        chk("st_exec", 32'(state), 32'(3)); adv();
        chk("st_stop", 32'(state), 32'(4));
        chk("st_retired", 32'(retired), 32'(1));
        for (int k = 0; k < 2; k++) begin
            resume = 1; adv(); resume = 0;
            chk("st_fetch", 32'(state), 32'(1)); adv();
            chk("st_decode", 32'(state), 32'(2)); adv();
            chk("st_exec", 32'(state), 32'(3)); adv();
            chk("st_stop", 32'(state), 32'(4));
            chk("st_retired", 32'(retired), 32'(2 + k));
        end
        step_en = 0;
`endif

        // Exhaustion on the 4-word instance
        for (int i = 0; i < 4; i++) beat(1, 1, 12'(12'h300 + i), 0, 1, i);
        chk("ex_state", 32'(s_state), 32'(1));
        chk("ex_full",  32'(s_load_full), 32'(1));
        chk("ex_done",  32'(s_load_done), 32'(1));
        chk("ex_count", 32'(s_load_count), 32'(4));
        s_load_valid = 1; #1;
        chk("ex_ready", 32'(s_load_ready), 32'(0));
        chk("ex_we",    32'(s_pmem_load_we), 32'(0));
        s_load_valid = 0;

        chk("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mcu_sequencer.md
Name: mcu_sequencer

Overview:
Upstream neighbour of the microcontroller control unit. Generates the 3-bit machine `state` the control unit decodes.
- Owns program-load sequencing: handshake, PMem load address and word count.
- Owns the FETCH/DECODE/EXECUTE rotation and halt/resume/reload into and out of STOP.
- Keeps a retired-instruction counter for debug.

Parameters:
ADDR_W, 8, PMem address width; PMem depth = 2**ADDR_W words
INSTR_W, 12, instruction word width
CNT_W, 16, retired-instruction counter width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  program word on load_data is valid
load_data  input  INSTR_W  program word to write into PMem
load_last  input  1  qualifies final word of program (meaningful only with load_valid)
load_ready  output  1  sequencer accepts a load word this cycle
pmem_load_we  output  1  accepted beat; PMem write strobe qualifier
pmem_load_addr  output  ADDR_W  PMem write address for current beat
pmem_load_data  output  INSTR_W  PMem write data (combinational pass-through of load_data)
halt_req  input  1  level; request stop at the next instruction boundary
resume  input  1  pulse; leave STOP and continue at FETCH
reload  input  1  pulse; leave STOP and re-enter LOAD
state  output  3  LOAD=3'b000, FETCH=3'b001, DECODE=3'b010, EXECUTE=3'b011, STOP=3'b100
load_done  output  1  sticky; program load completed
load_full  output  1  sticky; load ended by address exhaustion, not load_last
load_count  output  ADDR_W+1  words accepted in the last or current load
retired  output  CNT_W  EXECUTE cycles completed; saturates at all-ones

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous and active-low. All registers clear immediately when it asserts and release on the first clk edge after deassertion.
- Reset values: state=LOAD, pmem_load_addr=0, load_count=0, load_done=0, load_full=0, retired=0.
- Reset mid-operation, including mid-load, discards progress and restarts LOAD at address 0.
- load_ready = (state==LOAD), combinational.
- Beat accept = load_valid && load_ready. pmem_load_we = accept, same cycle. pmem_load_addr = current address register.
- On accept: address += 1 and load_count += 1, effective next edge.
- Leaving LOAD: on an accepted beat with load_last=1, OR an accepted beat at address 2**ADDR_W-1, next state is FETCH and load_done is set.
  - If the exit was by exhaustion without load_last, load_full is also set.
  - The address does not wrap into further writes; it is cleared on the next LOAD entry.
  - load_last with load_valid=0 is ignored.
- LOAD with no accepted beats holds indefinitely.
- Run rotation: FETCH -> DECODE -> EXECUTE, exactly one cycle each, no wait states.
  - At the EXECUTE edge: retired += 1, saturating.
  - Next state is STOP if halt_req=1, else FETCH.
- halt_req is sampled only in EXECUTE. In LOAD, FETCH or DECODE it does not truncate the current instruction.
- STOP:
  - Holds until reload or resume.
  - reload -> LOAD: pmem_load_addr=0, load_count=0, load_done=0, load_full=0. retired is preserved.
  - resume -> FETCH.
  - reload and resume in the same cycle: reload wins.
  - resume/reload outside STOP are ignored.
  - halt_req still high on resume is honoured again at the next EXECUTE, giving one instruction per resume.
- Encodings other than the five listed are unreachable. If ever observed, next state is STOP.

Optional Feature:
Macro MCU_SEQ_STEP_EN.
- Defined: adds input `step_en` (1 bit, level). With step_en=1, every EXECUTE is followed by STOP regardless of halt_req, giving single-step via resume.
- Undefined: port absent; EXECUTE -> STOP only via halt_req.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then 3 beats (data 12'h101, 12'h202, 12'h3FF, load_last on 3rd) with load_valid held -> pmem_load_we on 3 consecutive cycles at addr 0,1,2; next state FETCH; load_done=1, load_full=0, load_count=3.
- load_valid gaps: beat, 2 idle cycles, beat with last -> only 2 writes, addr 0 then 1; state stays LOAD during idle cycles.
- ADDR_W=2, 4 beats without load_last -> exit to FETCH after 4th; load_full=1, load_count=4; a 5th load_valid is not accepted (load_ready=0).
- Run 5 instructions, then assert halt_req during DECODE of 6th -> state sequence 1,2,3 repeating; STOP after 6th EXECUTE; retired=6; resume -> FETCH.
- In STOP, pulse reload and resume in same cycle -> LOAD, addr 0, load_done=0, retired unchanged; async rst_n pulse mid-load at addr 5 -> state=LOAD, addr 0 immediately without a clock edge.
- MCU_SEQ_STEP_EN defined, step_en=1: each resume yields exactly FETCH, DECODE, EXECUTE, STOP and retired +1 per resume.
